// File: rtl/demux32_assembler.sv
// Receive end of the 32:1 bit-select path: assembles (bit, select) beats into words
// and hands completed words to a one-deep valid/ready output slot.
module demux32_assembler #(
  parameter  int unsigned N     = 32,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [0:SEL_W-1] in_select,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:N-1]     out_data,
  output logic [0:N-1]     out_mask,
  output logic             err_dup
);

  typedef enum logic [0:0] {COLLECT = 1'b0, STALL = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [0:N-1]   asm_data_q, asm_data_d;
  logic [0:N-1]   asm_mask_q, asm_mask_d;
  logic [0:N-1]   out_data_q, out_data_d;
  logic [0:N-1]   out_mask_q, out_mask_d;
  logic           out_valid_q, out_valid_d;
  logic           err_dup_q, err_dup_d;

  logic [0:N-1]   onehot;
  logic [0:N-1]   beat_data;
  logic [0:N-1]   beat_mask;
  logic           accept;
  logic           complete;
  logic           slot_free;
  logic           drain;

  // Decode of the registered state only, so in_ready never sees in_*.
  assign in_ready  = (state_q == COLLECT);
  assign accept    = in_valid & in_ready;
  assign slot_free = ~out_valid_q | out_ready;
  assign drain     = out_valid_q & out_ready;

  always_comb begin
    onehot            = '0;
    onehot[in_select] = 1'b1;
  end

  // Word as it would look with the current beat merged in.
  assign beat_mask = asm_mask_q | onehot;
  assign beat_data = (asm_data_q & ~onehot) | (in_bit ? onehot : '0);
  assign complete  = accept & ((&beat_mask) | in_last);

  // State register plus datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COLLECT;
      asm_data_q  <= '0;
      asm_mask_q  <= '0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_valid_q <= 1'b0;
      err_dup_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_data_q  <= asm_data_d;
      asm_mask_q  <= asm_mask_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_valid_q <= out_valid_d;
      err_dup_q   <= err_dup_d;
    end
  end

  // Next-state: a completed word that cannot reach the slot parks in asm.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (complete && !slot_free) state_d = STALL;
      STALL:   if (drain)                  state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    asm_data_d  = asm_data_q;
    asm_mask_d  = asm_mask_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_valid_d = out_valid_q;
    err_dup_d   = accept & asm_mask_q[in_select];
    unique case (state_q)
      STALL: begin
        if (drain) begin
          out_data_d  = asm_data_q;
          out_mask_d  = asm_mask_q;
          out_valid_d = 1'b1;
          asm_data_d  = '0;
          asm_mask_d  = '0;
        end
      end
      default: begin
        if (drain) out_valid_d = 1'b0;
        if (complete && slot_free) begin
          out_data_d  = beat_data;
          out_mask_d  = beat_mask;
          out_valid_d = 1'b1;
          asm_data_d  = '0;
          asm_mask_d  = '0;
        end else if (accept) begin
          asm_data_d = beat_data;
          asm_mask_d = beat_mask;
        end
      end
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign err_dup   = err_dup_q;

endmodule
